// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: issues word reads to a synchronous
// instruction memory, buffers {pc, instruction} pairs and hands them to ID.
module fetch_unit #(
  parameter int PC_WIDTH = 9,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [PC_WIDTH-1:0]      imem_address,
  output logic                     imem_read,
  input  logic [XLEN-1:0]          imem_q,
  input  logic                     redirect,
  input  logic [PC_WIDTH-1:0]      redirect_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instruction,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0]     instr_mem [DEPTH];

  logic          push;
  logic          pop;
  logic          issue;
  logic [AW+1:0] committed;

  // Handshake: the head transfers to ID on a cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and a
  // redirect in the same cycle cancels the transfer.
  assign out_valid       = (occupancy != '0);
  assign pop             = out_valid & out_ready & ~redirect;
  assign push            = inflight & ~redirect;
  assign out_instruction = instr_mem[rd_ptr];
  assign out_pc          = pc_mem[rd_ptr];

  // Credit check: an entry already in memory flight reserves a FIFO slot, so
  // a return can never find the buffer full.
  assign committed    = {1'b0, occupancy} + {{(AW+1){1'b0}}, inflight}
                      - {{(AW+1){1'b0}}, pop};
  assign issue        = reset & ~redirect & (committed < (AW+2)'(DEPTH));
  assign imem_read    = issue;
  assign imem_address = fetch_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
    end else if (redirect) begin
      fetch_pc  <= redirect_address;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + PC_WIDTH'(1);
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Payload storage needs no reset; validity is carried by the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of the
// prefetch buffer, checked once per cycle.
module tb_fetch_unit;

  localparam int PCW   = 9;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clock;
  logic            reset;
  logic [PCW-1:0]  imem_address;
  logic            imem_read;
  logic [XLEN-1:0] imem_q;
  logic            redirect;
  logic [PCW-1:0]  redirect_address;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instruction;
  logic [PCW-1:0]  out_pc;
  logic [2:0]      occupancy;

  fetch_unit #(.PC_WIDTH(PCW), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_read        (imem_read),
    .imem_q           (imem_q),
    .redirect         (redirect),
    .redirect_address (redirect_address),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .occupancy        (occupancy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // instruction memory: address registered, data valid next cycle
  logic [XLEN-1:0] mem [1 << PCW];
  always @(posedge clock) if (imem_read) imem_q <= mem[imem_address];

  // reference model state
  logic [PCW+XLEN-1:0] exp_q[$];   // buffered {pc, instr}, head at index 0
  int                  pend_q[$];  // pcs requested but not yet returned
  int                  next_pc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend_q.delete();
    next_pc = 0;
  endtask

  // One cycle: drive inputs at the negedge, check, then advance the model
  // across the following rising edge.
  task automatic step(input logic rdy, input logic rdr, input logic [PCW-1:0] ra);
    int  occ;
    int  pend;
    bit  pop_m;
    bit  issue_m;
    logic [PCW+XLEN-1:0] head;
    out_ready        = rdy;
    redirect         = rdr;
    redirect_address = ra;
    #1;
    occ     = exp_q.size();
    pend    = pend_q.size();
    pop_m   = (occ > 0) && rdy && !rdr;
    issue_m = !rdr && (occ + pend - int'(pop_m) < DEPTH);
    check("imem_read", imem_read, issue_m);
    check("imem_address", imem_address, next_pc);
    check("out_valid", out_valid, occ != 0);
    check("occupancy", occupancy, occ);
    if (occ > 0) begin
      head = exp_q[0];
      check("out_pc", out_pc, head[PCW+XLEN-1:XLEN]);
      check("out_instruction", out_instruction, head[XLEN-1:0]);
    end
    if (rdr) begin
      exp_q.delete();
      pend_q.delete();
      next_pc = int'(ra);
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (pend > 0) begin
        int p;
        p = pend_q.pop_front();
        exp_q.push_back({PCW'(p), mem[p]});
      end
      if (issue_m) begin
        pend_q.push_back(next_pc);
        next_pc = (next_pc + 1) % (1 << PCW);
      end
    end
    @(negedge clock);
  endtask

  initial begin
    for (int a = 0; a < (1 << PCW); a++) mem[a] = $urandom;
    reset = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_address = '0;
    imem_q = '0;
    model_clear();
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset imem_read", imem_read, 0);
    check("reset imem_address", imem_address, 0);
    check("reset occupancy", occupancy, 0);
    @(negedge clock);
    reset = 1'b1;

    // streaming from 0 with ID always ready
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
    // stall until the buffer fills, then drain
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    // redirect with the buffer partly full and a read in flight
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 9'h040);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    // redirect with the buffer full
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 9'h100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 9'h1FD);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    // full buffer, then pop and push together
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    // asynchronous reset mid-cycle with entries buffered
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("async out_valid", out_valid, 0);
    check("async imem_address", imem_address, 0);
    check("async imem_read", imem_read, 0);
    check("async occupancy", occupancy, 0);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // randomized mix of stalls and redirects
    for (int i = 0; i < 400; i++) begin
      logic rdy;
      logic rdr;
      rdy = ($urandom_range(0, 3) != 0);
      rdr = ($urandom_range(0, 11) == 0);
      step(rdy, rdr, PCW'($urandom_range(0, (1 << PCW) - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
